// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - unified instruction/data memory responder with fixed-latency valid/ready response
// Optional MEM_FASTHIT_EN: a repeat read of the last completed read word responds one cycle after accept.
module mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  mem_we,
   input  logic                  mem_in,
   input  logic [31:0]           pc_addr,
   input  logic [31:0]           alu_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  err_misaligned,
   output logic                  busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   word_q, word_d;
   logic                    we_q, we_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic [31:0]             sel_addr;
   logic [ADDR_WIDTH-1:0]   sel_word;
   logic                    aligned;
   logic                    accept;
   logic                    fast_hit;
   logic [DATA_WIDTH-1:0]   access_data;
   logic                    unused_addr_bits;

   // Upper address bits are dropped so accesses wrap modulo the array depth.
   assign sel_addr         = mem_in ? alu_addr : pc_addr;
   assign sel_word         = sel_addr[ADDR_WIDTH+1:2];
   assign aligned          = (sel_addr[1:0] == 2'b00);
   assign unused_addr_bits = ^sel_addr[31:ADDR_WIDTH+2];

   assign req_ready      = (state_q == IDLE);
   assign busy           = (state_q != IDLE);
   assign accept         = req_valid && req_ready;
   assign err_misaligned = err_q;
   assign access_data    = we_q ? wdata_q : mem_q[word_q];

`ifdef MEM_FASTHIT_EN
   logic                  hit_valid_q;
   logic [ADDR_WIDTH-1:0] hit_word_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_valid_q <= 1'b0;
         hit_word_q  <= '0;
      end else if (state_q == RESP) begin
         if (we_q) begin
            hit_valid_q <= 1'b0;
         end else begin
            hit_valid_q <= 1'b1;
            hit_word_q  <= word_q;
         end
      end
   end

   assign fast_hit = hit_valid_q && (hit_word_q == sel_word) && !mem_we;
`else
   assign fast_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      err_d      = 1'b0;
      rdata_d    = rdata_q;
      resp_valid = 1'b0;
      resp_data  = rdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!aligned) begin
                  err_d = 1'b1;
               end else begin
                  word_d  = sel_word;
                  we_d    = mem_we;
                  wdata_d = wr_data;
                  if (LATENCY == 1 || fast_hit) begin
                     state_d = RESP;
                     cnt_d   = 3'd0;
                  end else begin
                     state_d = WAIT;
                     cnt_d   = LAT_M1;
                  end
               end
            end
         end
         WAIT: begin
            if (cnt_q == 3'd1) begin
               state_d = RESP;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_data  = access_data;
            rdata_d    = access_data;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         word_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Array is not reset; a write lands at the end of RESP unless reset aborts it.
   always_ff @(posedge clk) begin
      if (!rst && state_q == RESP && we_q) begin
         mem_q[word_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder at LATENCY 2 and 4
module tb_mem_responder;

   logic        clk;
   logic        rst;
   logic        req_valid_s [2];
   logic        req_ready_s [2];
   logic        mem_we_s    [2];
   logic        mem_in_s    [2];
   logic [31:0] pc_addr_s   [2];
   logic [31:0] alu_addr_s  [2];
   logic [31:0] wr_data_s   [2];
   logic        resp_valid_s[2];
   logic [31:0] resp_data_s [2];
   logic        err_s       [2];
   logic        busy_s      [2];

   int checks   = 0;
   int failures = 0;

`ifdef MEM_FASTHIT_EN
   localparam int HIT_LAT = 1;
`else
   localparam int HIT_LAT = 4;
`endif

   mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(2)) u_lat2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]),
      .mem_we(mem_we_s[0]), .mem_in(mem_in_s[0]),
      .pc_addr(pc_addr_s[0]), .alu_addr(alu_addr_s[0]), .wr_data(wr_data_s[0]),
      .resp_valid(resp_valid_s[0]), .resp_data(resp_data_s[0]),
      .err_misaligned(err_s[0]), .busy(busy_s[0])
   );

   mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(4)) u_lat4 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]),
      .mem_we(mem_we_s[1]), .mem_in(mem_in_s[1]),
      .pc_addr(pc_addr_s[1]), .alu_addr(alu_addr_s[1]), .wr_data(wr_data_s[1]),
      .resp_valid(resp_valid_s[1]), .resp_data(resp_data_s[1]),
      .err_misaligned(err_s[1]), .busy(busy_s[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one request, then count cycles from the accept edge until resp_valid.
   task automatic xfer(input int d, input logic we, input logic sel, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] wd, input int exp_lat,
                       input logic [31:0] exp_data, input string tag);
      int          lat;
      logic [31:0] got;
      lat = 0;
      got = '0;
      check({tag, "_ready"}, 32'(req_ready_s[d]), 32'd1);
      mem_we_s[d]    = we;
      mem_in_s[d]    = sel;
      pc_addr_s[d]   = pc;
      alu_addr_s[d]  = alu;
      wr_data_s[d]   = wd;
      req_valid_s[d] = 1'b1;
      step();
      req_valid_s[d] = 1'b0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         if (n > 1) step();
         if (resp_valid_s[d]) begin
            lat = n;
            got = resp_data_s[d];
         end
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_data"}, got, exp_data);
      step();
   endtask

   initial begin
      int seen_resp;
      int seen_err;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_valid_s[d] = 1'b0;
         mem_we_s[d]    = 1'b0;
         mem_in_s[d]    = 1'b0;
         pc_addr_s[d]   = '0;
         alu_addr_s[d]  = '0;
         wr_data_s[d]   = '0;
      end
      step();
      step();
      check("rst_ready", 32'(req_ready_s[0]), 32'd1);
      check("rst_resp_valid", 32'(resp_valid_s[0]), 32'd0);
      check("rst_resp_data", resp_data_s[0], 32'd0);
      check("rst_busy", 32'(busy_s[0]), 32'd0);
      check("rst_err", 32'(err_s[0]), 32'd0);
      rst = 1'b0;
      step();

      // LATENCY=2: write/read, address select and wrap
      xfer(0, 1'b1, 1'b1, 32'h0, 32'h10, 32'hDEADBEEF, 2, 32'hDEADBEEF, "wr10");
      xfer(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 2, 32'hDEADBEEF, "rd10");
      xfer(0, 1'b1, 1'b1, 32'h0, 32'h8, 32'h0BADF00D, 2, 32'h0BADF00D, "wr08");
      xfer(0, 1'b1, 1'b1, 32'h0, 32'h1004, 32'h12345678, 2, 32'h12345678, "wr1004");
      xfer(0, 1'b0, 1'b0, 32'h4, 32'h8, 32'h0, 2, 32'h12345678, "rd_pc04");
      xfer(0, 1'b0, 1'b1, 32'h4, 32'h8, 32'h0, 2, 32'h0BADF00D, "rd_alu08");

      // Misaligned requests: read at 0x6, then write at 0x6 which must not touch word 1
      mem_we_s[0] = 1'b0; mem_in_s[0] = 1'b1; alu_addr_s[0] = 32'h6; req_valid_s[0] = 1'b1;
      step();
      req_valid_s[0] = 1'b0;
      check("mis_err", 32'(err_s[0]), 32'd1);
      check("mis_ready", 32'(req_ready_s[0]), 32'd1);
      check("mis_busy", 32'(busy_s[0]), 32'd0);
      mem_we_s[0] = 1'b1; wr_data_s[0] = 32'hFFFFFFFF; req_valid_s[0] = 1'b1;
      step();
      req_valid_s[0] = 1'b0;
      check("mis_wr_err", 32'(err_s[0]), 32'd1);
      seen_resp = 0;
      seen_err  = 0;
      for (int n = 0; n < 4; n++) begin
         step();
         if (resp_valid_s[0]) seen_resp++;
         if (err_s[0]) seen_err++;
      end
      check("mis_no_resp", 32'(seen_resp), 32'd0);
      check("mis_err_pulse", 32'(seen_err), 32'd0);
      xfer(0, 1'b0, 1'b0, 32'h4, 32'h0, 32'h0, 2, 32'h12345678, "mis_mem");

      // LATENCY=4: busy window with req_valid held high
      xfer(1, 1'b1, 1'b1, 32'h0, 32'hC, 32'h11112222, 4, 32'h11112222, "wr0c");
      mem_we_s[1] = 1'b0; mem_in_s[1] = 1'b0; pc_addr_s[1] = 32'hC; req_valid_s[1] = 1'b1;
      step();
      seen_resp = 0;
      for (int n = 1; n <= 4; n++) begin
         check($sformatf("busy_ready_%0d", n), 32'(req_ready_s[1]), 32'd0);
         check($sformatf("busy_resp_%0d", n), 32'(resp_valid_s[1]), (n == 4) ? 32'd1 : 32'd0);
         if (resp_valid_s[1]) seen_resp++;
         step();
      end
      check("busy_ready_back", 32'(req_ready_s[1]), 32'd1);
      req_valid_s[1] = 1'b0;
      step();
      check("busy_idle", 32'(busy_s[1]), 32'd0);
      check("busy_one_resp", 32'(seen_resp), 32'd1);

      // Reset two cycles after accepting a write aborts it
      mem_we_s[1] = 1'b1; mem_in_s[1] = 1'b1; alu_addr_s[1] = 32'hC;
      wr_data_s[1] = 32'hAAAA5555; req_valid_s[1] = 1'b1;
      step();
      req_valid_s[1] = 1'b0;
      seen_resp = 0;
      step();
      if (resp_valid_s[1]) seen_resp++;
      step();
      rst = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         if (resp_valid_s[1]) seen_resp++;
      end
      check("abort_resp_data", resp_data_s[1], 32'd0);
      check("abort_busy", 32'(busy_s[1]), 32'd0);
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         step();
         if (resp_valid_s[1]) seen_resp++;
      end
      check("abort_no_resp", 32'(seen_resp), 32'd0);
      xfer(1, 1'b0, 1'b0, 32'hC, 32'h0, 32'h0, 4, 32'h11112222, "abort_old");

      // Repeat-read hit tracking
      xfer(1, 1'b1, 1'b1, 32'h0, 32'h20, 32'h5A5A0001, 4, 32'h5A5A0001, "fh_wr1");
      xfer(1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 4, 32'h5A5A0001, "fh_rd1");
      xfer(1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, HIT_LAT, 32'h5A5A0001, "fh_rd2");
      xfer(1, 1'b1, 1'b1, 32'h0, 32'h20, 32'h5A5A0002, 4, 32'h5A5A0002, "fh_wr2");
      xfer(1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 4, 32'h5A5A0002, "fh_rd3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
